fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-side sequencer between the PC register of the fetch stage and the instruction cache. It chooses the next-PC source each cycle and issues one instruction-cache request at a time. It holds a returned instruction while decode stalls. It also absorbs commit redirects that arrive while a cache request is outstanding, so a stale response never reaches decode and the PC never changes under an in-flight request.

## Interface
- ADDR_W, 40, virtual address width (matches addr_t)
- CNT_W, 32, width of performance counters
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  decode cannot accept a fetch packet this cycle
- redirect_valid_i  in  1  commit redirect request, single-cycle pulse
- redirect_pc_i  in  ADDR_W  redirect target, valid with redirect_valid_i
- icache_ready_i  in  1  icache accepts a request this cycle
- icache_resp_valid_i  in  1  icache returns data for the accepted request
- next_pc_sel_o  out  next_pc_sel_t  PC mux select to fetch stage
- pc_commit_o  out  ADDR_W  value driven to the fetch-stage pc_commit_i
- icache_req_valid_o  out  1  request valid for the current PC
- icache_kill_o  out  1  one-cycle kill of the outstanding request
- fetch_valid_o  out  1  gated fetch packet valid toward decode
- fetch_cnt_o  out  CNT_W  instructions delivered (fetch_valid_o && !stall_i)
- miss_cyc_o  out  CNT_W  cycles spent in WAIT_RESP beyond the first

## Operation
- FSM states: BOOT, REQ, WAIT_RESP, HOLD. The default output in every state is next_pc_sel_o=NEXT_PC_SEL_PC, which holds the PC.
- BOOT (reset state): icache_req_valid_o=0. Go to REQ unconditionally on the next cycle.
- REQ: icache_req_valid_o=1.
  - icache_ready_i=1: go to WAIT_RESP.
  - Otherwise: stay in REQ.
- WAIT_RESP: icache_req_valid_o=0.
  - On icache_resp_valid_i with kill_pend=0:
    - fetch_valid_o=1.
    - stall_i=0: next_pc_sel_o=NEXT_PC_SEL_PC_4, go to REQ.
    - stall_i=1: go to HOLD.
  - On icache_resp_valid_i with kill_pend=1:
    - fetch_valid_o=0.
    - next_pc_sel_o=NEXT_PC_SEL_COMMIT, pc_commit_o=pend_pc.
    - Clear kill_pend, go to REQ.
- HOLD: fetch_valid_o=1 and the icache response data is held stable.
  - stall_i=0: next_pc_sel_o=NEXT_PC_SEL_PC_4, go to REQ.
- Redirect handling in BOOT, REQ or HOLD:
  - next_pc_sel_o=NEXT_PC_SEL_COMMIT, pc_commit_o=redirect_pc_i, icache_req_valid_o=0, fetch_valid_o=0.
  - Go to REQ.
- Redirect handling in WAIT_RESP without a same-cycle response:
  - Set kill_pend=1, pend_pc<=redirect_pc_i, icache_kill_o=1 for that cycle.
  - A later redirect before the response overwrites pend_pc; newest wins.
- Redirect and response in the same WAIT_RESP cycle:
  - Redirect wins. The response is discarded (fetch_valid_o=0).
  - next_pc_sel_o=NEXT_PC_SEL_COMMIT, pc_commit_o=redirect_pc_i, clear kill_pend, go to REQ.
- pc_commit_o muxes: redirect_pc_i when redirect_valid_i=1, otherwise pend_pc.
- Counters:
  - fetch_cnt_o and miss_cyc_o wrap modulo 2^CNT_W.
  - miss_cyc_o increments on each WAIT_RESP cycle after the first, including killed waits.
- icache_resp_valid_i outside WAIT_RESP is ignored. The icache guarantees at most one outstanding request.

## Timing
- Reset values: state=BOOT, next_pc_sel_o=NEXT_PC_SEL_PC, icache_req_valid_o=0, icache_kill_o=0, fetch_valid_o=0, pc_commit_o=0, kill_pend=0, pend_pc=0, both counters 0.
- All outputs are combinational from state, the registers and the inputs. There are no registered outputs other than the counters.
- Minimum steady-state fetch period is 2 cycles (REQ, then WAIT_RESP with same-cycle response).
- PC update takes effect the cycle after next_pc_sel_o is driven, because the fetch-stage PC register samples it at that edge.
- next_pc_sel_o ≠ NEXT_PC_SEL_PC only in the cycle the FSM leaves WAIT_RESP or HOLD, or on a redirect.
- Reset mid-request: the FSM returns to BOOT asynchronously and any outstanding response is ignored. The icache is reset by the same rstn_i.

## Test plan
- Reset, then icache_ready_i=1 with a response 1 cycle after accept:
  - BOOT→REQ→WAIT_RESP→REQ.
  - fetch_valid_o pulses every 2nd cycle and next_pc_sel_o=PC_4 on those cycles.
  - After 10 fetches, fetch_cnt_o=10.
- Miss: response arrives 5 cycles after accept.
  - icache_req_valid_o=0 throughout the wait.
  - miss_cyc_o=4, then one PC_4.
- Stall: response arrives with stall_i=1 for 3 cycles.
  - HOLD with fetch_valid_o=1 for 3 cycles, no PC change.
  - PC_4 on the cycle stall drops; fetch_cnt_o increments once.
- Redirect while in WAIT_RESP:
  - Redirect to 0x80, then redirect to 0x200 before the response.
  - icache_kill_o pulses on each redirect.
  - Response is dropped (fetch_valid_o=0); COMMIT with pc_commit_o=0x200.
- Same-cycle redirect(0x300) and response: response is dropped, COMMIT with pc_commit_o=0x300, kill_pend=0 afterwards.
- Redirect(0x400) in HOLD and in REQ with icache_ready_i=0:
  - Immediate COMMIT with pc_commit_o=0x400, fetch_valid_o=0.
  - FSM goes to REQ and no request is accepted that cycle.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-side sequencer between the fetch-stage PC register and the
// instruction cache. Selects the next-PC source, issues one icache request at a
// time, holds a returned packet while decode stalls, and absorbs commit
// redirects that land while a request is outstanding.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   stall_i                decode cannot accept a fetch packet
//   redirect_valid_i/pc_i  commit redirect pulse and target
//   icache_ready_i         icache accepts the request this cycle
//   icache_resp_valid_i    icache returns data for the accepted request
//   next_pc_sel_o          PC mux select (0=PC, 1=PC_4, 2=COMMIT)
//   pc_commit_o            commit target driven to the fetch stage
//   icache_req_valid_o     request valid for the current PC
//   icache_kill_o          one-cycle kill of the outstanding request
//   fetch_valid_o          fetch packet valid toward decode
//   fetch_cnt_o            delivered instruction count (wraps)
//   miss_cyc_o             WAIT_RESP cycles beyond the first (wraps)
module fetch_ctrl #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              icache_ready_i,
  input  logic              icache_resp_valid_i,
  output logic [1:0]        next_pc_sel_o,
  output logic [ADDR_W-1:0] pc_commit_o,
  output logic              icache_req_valid_o,
  output logic              icache_kill_o,
  output logic              fetch_valid_o,
  output logic [CNT_W-1:0]  fetch_cnt_o,
  output logic [CNT_W-1:0]  miss_cyc_o
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] NEXT_PC_SEL_PC     = 2'd0;
  localparam logic [1:0] NEXT_PC_SEL_PC_4   = 2'd1;
  localparam logic [1:0] NEXT_PC_SEL_COMMIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              kill_pend_q, kill_pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              was_wait_q, was_wait_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  miss_cyc_q, miss_cyc_d;

  // Next-state and combinational outputs.
  always_comb begin
    state_d            = state_q;
    kill_pend_d        = kill_pend_q;
    pend_pc_d          = pend_pc_q;
    next_pc_sel_o      = NEXT_PC_SEL_PC;
    icache_req_valid_o = 1'b0;
    icache_kill_o      = 1'b0;
    fetch_valid_o      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (redirect_valid_i) next_pc_sel_o = NEXT_PC_SEL_COMMIT;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        // A redirect suppresses the request so it is issued for the new PC.
        if (redirect_valid_i) begin
          next_pc_sel_o = NEXT_PC_SEL_COMMIT;
        end else begin
          icache_req_valid_o = 1'b1;
          if (icache_ready_i) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid_i && icache_resp_valid_i) begin
          // Request already completed: apply the redirect directly.
          next_pc_sel_o = NEXT_PC_SEL_COMMIT;
          kill_pend_d   = 1'b0;
          state_d       = ST_REQ;
        end else if (redirect_valid_i) begin
          // PC must not move under the in-flight request; park the target.
          kill_pend_d   = 1'b1;
          pend_pc_d     = redirect_pc_i;
          icache_kill_o = 1'b1;
        end else if (icache_resp_valid_i) begin
          if (kill_pend_q) begin
            next_pc_sel_o = NEXT_PC_SEL_COMMIT;
            kill_pend_d   = 1'b0;
            state_d       = ST_REQ;
          end else begin
            fetch_valid_o = 1'b1;
            if (!stall_i) begin
              next_pc_sel_o = NEXT_PC_SEL_PC_4;
              state_d       = ST_REQ;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid_i) begin
          next_pc_sel_o = NEXT_PC_SEL_COMMIT;
          state_d       = ST_REQ;
        end else begin
          fetch_valid_o = 1'b1;
          if (!stall_i) begin
            next_pc_sel_o = NEXT_PC_SEL_PC_4;
            state_d       = ST_REQ;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign pc_commit_o = redirect_valid_i ? redirect_pc_i : pend_pc_q;

  // Performance counters; consecutive WAIT cycles always belong to one request.
  always_comb begin
    was_wait_d  = (state_q == ST_WAIT);
    fetch_cnt_d = fetch_cnt_q + CNT_W'(fetch_valid_o && !stall_i);
    miss_cyc_d  = miss_cyc_q + CNT_W'((state_q == ST_WAIT) && was_wait_q);
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign miss_cyc_o  = miss_cyc_q;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_BOOT;
      kill_pend_q <= 1'b0;
      pend_pc_q   <= '0;
      was_wait_q  <= 1'b0;
      fetch_cnt_q <= '0;
      miss_cyc_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      pend_pc_q   <= pend_pc_d;
      was_wait_q  <= was_wait_d;
      fetch_cnt_q <= fetch_cnt_d;
      miss_cyc_q  <= miss_cyc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: per-cycle stimulus with expected outputs queued at
// drive time and compared on the following falling edge.
module tb_fetch_ctrl;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned CNT_W  = 32;

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_PC4 = 2'd1;
  localparam logic [1:0] SEL_CMT = 2'd2;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              stall_i;
  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              icache_ready_i;
  logic              icache_resp_valid_i;
  logic [1:0]        next_pc_sel_o;
  logic [ADDR_W-1:0] pc_commit_o;
  logic              icache_req_valid_o;
  logic              icache_kill_o;
  logic              fetch_valid_o;
  logic [CNT_W-1:0]  fetch_cnt_o;
  logic [CNT_W-1:0]  miss_cyc_o;

  fetch_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .stall_i             (stall_i),
    .redirect_valid_i    (redirect_valid_i),
    .redirect_pc_i       (redirect_pc_i),
    .icache_ready_i      (icache_ready_i),
    .icache_resp_valid_i (icache_resp_valid_i),
    .next_pc_sel_o       (next_pc_sel_o),
    .pc_commit_o         (pc_commit_o),
    .icache_req_valid_o  (icache_req_valid_o),
    .icache_kill_o       (icache_kill_o),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_cnt_o         (fetch_cnt_o),
    .miss_cyc_o          (miss_cyc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string             tag;
    logic [1:0]        sel;
    logic              req;
    logic              kill;
    logic              fv;
    logic              chk_pc;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  mcnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Counter values the DUT should show in the next checked cycle.
  logic [CNT_W-1:0] exp_f = '0;
  logic [CNT_W-1:0] exp_m = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string tag, input logic st, input logic rv,
                      input logic [ADDR_W-1:0] rpc, input logic rdy, input logic rsp,
                      input logic [1:0] e_sel, input logic e_req, input logic e_kill,
                      input logic e_fv, input logic e_chk_pc, input logic [ADDR_W-1:0] e_pc);
    exp_t e;
    @(posedge clk_i);
    #1;
    stall_i             = st;
    redirect_valid_i    = rv;
    redirect_pc_i       = rpc;
    icache_ready_i      = rdy;
    icache_resp_valid_i = rsp;
    e.tag    = tag;
    e.sel    = e_sel;
    e.req    = e_req;
    e.kill   = e_kill;
    e.fv     = e_fv;
    e.chk_pc = e_chk_pc;
    e.pc     = e_pc;
    e.fcnt   = exp_f;
    e.mcnt   = exp_m;
    sb.push_back(e);
  endtask

  // Compare queued expectations against the DUT mid-cycle.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".sel"},  64'(next_pc_sel_o),      64'(e.sel));
      check_eq({e.tag, ".req"},  64'(icache_req_valid_o), 64'(e.req));
      check_eq({e.tag, ".kill"}, 64'(icache_kill_o),      64'(e.kill));
      check_eq({e.tag, ".fv"},   64'(fetch_valid_o),      64'(e.fv));
      check_eq({e.tag, ".fcnt"}, 64'(fetch_cnt_o),        64'(e.fcnt));
      check_eq({e.tag, ".mcnt"}, 64'(miss_cyc_o),         64'(e.mcnt));
      if (e.chk_pc) check_eq({e.tag, ".pc"}, 64'(pc_commit_o), 64'(e.pc));
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rstn_i              = 1'b0;
    stall_i             = 1'b0;
    redirect_valid_i    = 1'b0;
    redirect_pc_i       = '0;
    icache_ready_i      = 1'b0;
    icache_resp_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // Reset state.
    step("rst", 0, 0, '0, 0, 0, SEL_PC, 0, 0, 0, 1, '0);
    @(negedge clk_i);
    #2 rstn_i = 1'b1;

    // Back-to-back hits: fetch every second cycle.
    for (int i = 0; i < 10; i++) begin
      step("hit_req",  0, 0, '0, 1, 0, SEL_PC,  1, 0, 0, 0, '0);
      step("hit_resp", 0, 0, '0, 1, 1, SEL_PC4, 0, 0, 1, 0, '0);
      exp_f++;
    end

    // Miss: response 5 cycles after accept.
    step("miss_req", 0, 0, '0, 1, 0, SEL_PC, 1, 0, 0, 0, '0);
    step("miss_w1",  0, 0, '0, 0, 0, SEL_PC, 0, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      step("miss_w", 0, 0, '0, 0, 0, SEL_PC, 0, 0, 0, 0, '0);
      exp_m++;
    end
    step("miss_resp", 0, 0, '0, 0, 1, SEL_PC4, 0, 0, 1, 0, '0);
    exp_m++;
    exp_f++;

    // Stall: response held in HOLD until decode frees up.
    step("stl_req",  0, 0, '0, 1, 0, SEL_PC, 1, 0, 0, 0, '0);
    step("stl_resp", 1, 0, '0, 0, 1, SEL_PC, 0, 0, 1, 0, '0);
    for (int k = 0; k < 3; k++)
      step("stl_hold", 1, 0, '0, 0, 0, SEL_PC, 0, 0, 1, 0, '0);
    step("stl_rel", 0, 0, '0, 0, 0, SEL_PC4, 0, 0, 1, 0, '0);
    exp_f++;

    // Two redirects while waiting; newest target wins, response dropped.
    step("rw_req",  0, 0, '0,          1, 0, SEL_PC,  1, 0, 0, 0, '0);
    step("rw_k1",   0, 1, 40'h80,      0, 0, SEL_PC,  0, 1, 0, 1, 40'h80);
    step("rw_idle", 0, 0, '0,          0, 0, SEL_PC,  0, 0, 0, 1, 40'h80);
    exp_m++;
    step("rw_k2",   0, 1, 40'h200,     0, 0, SEL_PC,  0, 1, 0, 1, 40'h200);
    exp_m++;
    step("rw_drop", 0, 0, '0,          0, 1, SEL_CMT, 0, 0, 0, 1, 40'h200);
    exp_m++;

    // Redirect and response in the same cycle; later fetch is not dropped.
    step("sc_req",   0, 0, '0,      1, 0, SEL_PC,  1, 0, 0, 0, '0);
    step("sc_same",  0, 1, 40'h300, 0, 1, SEL_CMT, 0, 0, 0, 1, 40'h300);
    step("sc_req2",  0, 0, '0,      1, 0, SEL_PC,  1, 0, 0, 0, '0);
    step("sc_resp",  0, 0, '0,      0, 1, SEL_PC4, 0, 0, 1, 0, '0);
    exp_f++;

    // Redirect in HOLD, then in REQ with the icache not ready.
    step("hr_req",   0, 0, '0,      1, 0, SEL_PC,  1, 0, 0, 0, '0);
    step("hr_resp",  1, 0, '0,      0, 1, SEL_PC,  0, 0, 1, 0, '0);
    step("hr_redir", 1, 1, 40'h400, 0, 0, SEL_CMT, 0, 0, 0, 1, 40'h400);
    step("rq_redir", 0, 1, 40'h400, 0, 0, SEL_CMT, 0, 0, 0, 1, 40'h400);
    step("rq_ign",   0, 0, '0,      0, 1, SEL_PC,  1, 0, 0, 0, '0);
    step("rq_req",   0, 0, '0,      1, 0, SEL_PC,  1, 0, 0, 0, '0);
    step("rq_resp",  0, 0, '0,      0, 1, SEL_PC4, 0, 0, 1, 0, '0);
    exp_f++;
    step("final",    0, 0, '0,      0, 0, SEL_PC,  1, 0, 0, 0, '0);

    repeat (2) @(negedge clk_i);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
